// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit. It computes one radix-2 step per cycle for 32 cycles,
// works on operand magnitudes, and applies sign correction as it writes {hi, lo} into prod.
module muldiv_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [63:0] prod
);

    // state  | meaning
    // S_IDLE | waiting for start
    // S_CALC | 32 radix-2 iterations, counter 0..31
    // S_DONE | prod just updated, done pulse; start here issues back-to-back
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        neg_q, neg_d;
    logic        rneg_q, rneg_d;
    logic [63:0] prod_q, prod_d;

    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic        div_ge;
    logic [31:0] iter_hi, iter_lo;
    logic [63:0] mul_full;

    always_comb begin
        a_neg = ~op[0] & src_a[31];
        b_neg = ~op[0] & src_b[31];
        a_mag = a_neg ? (~src_a + 32'd1) : src_a;
        b_mag = b_neg ? (~src_b + 32'd1) : src_b;

        // Multiply: shift-add with lo holding the multiplier. Divide: restoring, lo collects quotient bits.
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : 33'd0);
        div_shift = {hi_q, lo_q[31]};
        div_ge    = (div_shift >= {1'b0, b_q});
        if (op_q[1]) begin
            iter_hi = div_ge ? (div_shift[31:0] - b_q) : div_shift[31:0];
            iter_lo = {lo_q[30:0], div_ge};
        end else begin
            iter_hi = mul_sum[32:1];
            iter_lo = {mul_sum[0], lo_q[31:1]};
        end
        mul_full = {iter_hi, iter_lo};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        prod_d  = prod_q;
        if (flush) begin
            state_d = S_IDLE;
        end else if (state_q == S_CALC) begin
            hi_d  = iter_hi;
            lo_d  = iter_lo;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
                state_d = S_DONE;
                if (!op_q[1]) begin
                    prod_d = neg_q ? (~mul_full + 64'd1) : mul_full;
                end else if (b_q == 32'd0) begin
                    prod_d = {a_q, 32'hFFFF_FFFF};
                end else begin
                    prod_d = {rneg_q ? (~iter_hi + 32'd1) : iter_hi,
                              neg_q  ? (~iter_lo + 32'd1) : iter_lo};
                end
            end
        end else if (start) begin
            state_d = S_CALC;
            cnt_d   = 5'd0;
            op_d    = op;
            a_d     = src_a;
            b_d     = b_mag;
            hi_d    = 32'd0;
            lo_d    = a_mag;
            neg_d   = a_neg ^ b_neg;
            rneg_d  = a_neg;
        end else begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            op_q    <= 2'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            prod_q  <= 64'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            prod_q  <= prod_d;
        end
    end

    assign busy = (state_q == S_CALC);
    assign done = (state_q == S_DONE);
    assign prod = prod_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized and directed bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op    = 2'd0;
    logic [31:0] src_a = 32'd0;
    logic [31:0] src_b = 32'd0;
    logic        flush = 1'b0;
    logic        busy, done;
    logic [63:0] prod;

    int total = 0;
    int bad   = 0;

    muldiv_unit dut (
        .clock(clock), .reset(reset), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .flush(flush),
        .busy(busy), .done(done), .prod(prod)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'd0: res = sa * sb;
            2'd1: res = {32'd0, a} * {32'd0, b};
            2'd2: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else res = {a % b, a / b};
            end
        endcase
        return res;
    endfunction

    // Drive start for one cycle; afterwards scramble operands to prove they were latched.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        op = o; src_a = a; src_b = b; start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        src_a = $urandom; src_b = $urandom; op = 2'($urandom_range(0, 3));
    endtask

    // Cycle 1 is the one right after the sampling edge; done is expected in cycle 33.
    task automatic wait_done(input int inject_at, output int lat, output int nbusy);
        lat = 1;
        nbusy = busy ? 1 : 0;
        while (!done && lat < 60) begin
            if (inject_at != 0 && lat == inject_at) begin
                start = 1'b1; op = 2'd0; src_a = 32'd6; src_b = 32'd7;
            end else if (inject_at != 0 && lat == inject_at + 1) begin
                start = 1'b0;
            end
            @(posedge clock);
            #1;
            lat++;
            if (busy) nbusy++;
        end
        start = 1'b0;
        if (!done) check("done_timeout", 64'(lat), 64'd33);
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        int lat, nbusy;
        logic [63:0] exp;
        exp = model(o, a, b);
        issue(o, a, b);
        wait_done(0, lat, nbusy);
        check({tag, "_prod"}, prod, exp);
        check({tag, "_lat"}, 64'(lat), 64'd33);
        check({tag, "_busy"}, 64'(nbusy), 64'd32);
        @(posedge clock);
        #1;
        check({tag, "_pulse"}, {63'd0, done}, 64'd0);
        check({tag, "_hold"}, prod, exp);
    endtask

    initial begin
        int lat, nbusy, ndone;
        logic [63:0] keep;
        logic [31:0] corners [5];
        logic [31:0] ra, rb;
        logic [1:0]  ro;

        corners[0] = 32'h0000_0000; corners[1] = 32'h8000_0000; corners[2] = 32'hFFFF_FFFF;
        corners[3] = 32'h7FFF_FFFF; corners[4] = 32'h0000_0001;

        #2;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_prod", prod, 64'd0);
        #20;
        @(negedge clock);
        reset = 1'b1;

        run_op("mult", 2'd0, 32'hFFFF_FFFE, 32'h0000_0003);
        check("mult_dir", prod, 64'hFFFF_FFFF_FFFF_FFFA);
        run_op("multu", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_dir", prod, 64'hFFFF_FFFE_0000_0001);
        run_op("div_neg", 2'd2, 32'hFFFF_FFF9, 32'h0000_0002);
        check("div_dir", prod, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_op("divu", 2'd3, 32'd100, 32'd7);
        check("divu_dir", prod, {32'h0000_0002, 32'h0000_000E});
        run_op("divu0", 2'd3, 32'h1234_5678, 32'd0);
        check("divu0_dir", prod, {32'h1234_5678, 32'hFFFF_FFFF});
        run_op("div0", 2'd2, 32'h8765_4321, 32'd0);
        run_op("divovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        check("divovf_dir", prod, {32'h0000_0000, 32'h8000_0000});

        for (int i = 0; i < 30; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
            if ($urandom_range(0, 2) == 0) rb = rb >> $urandom_range(1, 31);
            run_op("rand", ro, ra, rb);
        end

        // Start during CALC is ignored; start in the DONE cycle issues back-to-back.
        issue(2'd0, 32'd2, 32'd3);
        wait_done(10, lat, nbusy);
        check("b2b_first_lat", 64'(lat), 64'd33);
        check("b2b_first_prod", prod, 64'h6);
        start = 1'b1; op = 2'd0; src_a = 32'd6; src_b = 32'd7;
        @(posedge clock);
        #1;
        start = 1'b0;
        src_a = $urandom; src_b = $urandom;
        check("b2b_busy", {63'd0, busy}, 64'd1);
        wait_done(0, lat, nbusy);
        check("b2b_second_lat", 64'(lat), 64'd33);
        check("b2b_second_prod", prod, 64'h2A);

        // Flush mid-CALC.
        keep = prod;
        issue(2'd1, 32'h0001_0000, 32'h0001_0000);
        repeat (9) @(posedge clock);
        @(negedge clock);
        flush = 1'b1;
        @(posedge clock);
        #1;
        flush = 1'b0;
        check("flush_busy", {63'd0, busy}, 64'd0);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            if (done) ndone++;
        end
        check("flush_no_done", 64'(ndone), 64'd0);
        check("flush_prod", prod, keep);

        // Flush wins over start.
        @(negedge clock);
        start = 1'b1; flush = 1'b1; op = 2'd0; src_a = 32'd5; src_b = 32'd5;
        @(posedge clock);
        #1;
        start = 1'b0; flush = 1'b0;
        check("flush_prio_busy", {63'd0, busy}, 64'd0);

        // Asynchronous reset mid-CALC.
        issue(2'd0, 32'd9, 32'd9);
        repeat (4) @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        check("rstmid_prod", prod, 64'd0);
        check("rstmid_busy", {63'd0, busy}, 64'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            if (done) ndone++;
        end
        check("rstmid_no_done", 64'(ndone), 64'd0);
        run_op("after_rst", 2'd0, 32'hFFFF_FFFF, 32'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
